dtlb_resp: RTL and testbench

- Data-TLB responder on the far side of the AGU lookup interface.
- Accepts a lookup request (tlb_clkEn, addrTlb, sproc) from one AGU port.
- Returns translation data for the addressed page and for the page after it, with hit flags.
- Holds a small fully-associative entry array with a refill write port, round-robin replacement and a sequential invalidate-all walker.

---
 rtl/dtlb_resp.sv | 175 +++++++++++++++++
 tb/tb_dtlb_resp.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dtlb_resp.sv
// Data-TLB responder: fully-associative entry array with a one-cycle registered lookup
// of the addressed page and the next page, a round-robin refill port and an invalidate-all walker.
module dtlb_resp #(
   parameter int unsigned ENTRIES        = 16,
   parameter int unsigned TLB_DATA_WIDTH = 64,
   parameter int unsigned TLB_IP_WIDTH   = 52
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      tlb_clkEn,
   input  logic [TLB_IP_WIDTH-1:0]   addrTlb,
   input  logic [23:0]               sproc,
   output logic [TLB_DATA_WIDTH-1:0] tlb_data0,
   output logic [TLB_DATA_WIDTH-1:0] tlb_data1,
   output logic                      tlb_hit,
   output logic                      tlb_hit_next,
   input  logic                      wr_en,
   input  logic [TLB_IP_WIDTH-1:0]   wr_tag,
   input  logic [23:0]               wr_sproc,
   input  logic [TLB_DATA_WIDTH-1:0] wr_data,
   output logic                      wr_ack,
   input  logic                      inv_all,
   output logic                      busy
);

   localparam int unsigned IDX_W   = $clog2(ENTRIES);
   localparam int unsigned VPAGE_W = 31;
   localparam int unsigned SPROC_W = 24;

   typedef enum logic {IDLE, WALK} state_t;

   state_t                    state_q, state_d;
   logic [IDX_W-1:0]          inv_ptr_q, inv_ptr_d;
   logic [IDX_W-1:0]          rr_q;
   logic                      clr_c, rr_clr_c;

   logic [ENTRIES-1:0]        valid_q;
   logic [TLB_IP_WIDTH-1:0]   tag_q   [ENTRIES];
   logic [SPROC_W-1:0]        sproc_q [ENTRIES];
   logic [TLB_DATA_WIDTH-1:0] data_q  [ENTRIES];

   logic [VPAGE_W-1:0]        next_vpage_c;
   logic [TLB_IP_WIDTH-1:0]   next_tag_c;
   logic                      hit0_c, hit1_c;
   logic [TLB_DATA_WIDTH-1:0] data0_c, data1_c;

   logic                      wr_hit_c, wr_acc_c;
   logic [IDX_W-1:0]          wr_hit_idx_c, wr_idx_c;

   // Next page stays within the same proc id; vpage wraps modulo 2^31
   assign next_vpage_c = addrTlb[VPAGE_W-1:0] + VPAGE_W'(1);
   assign next_tag_c   = {addrTlb[TLB_IP_WIDTH-1:VPAGE_W], next_vpage_c};

   // Lookup match; multiple matches (illegal) OR their data words
   always_comb begin
      hit0_c  = 1'b0;
      hit1_c  = 1'b0;
      data0_c = '0;
      data1_c = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         if (valid_q[i] && (sproc_q[i] == sproc)) begin
            if (tag_q[i] == addrTlb) begin
               hit0_c  = 1'b1;
               data0_c = data0_c | data_q[i];
            end
            if (tag_q[i] == next_tag_c) begin
               hit1_c  = 1'b1;
               data1_c = data1_c | data_q[i];
            end
         end
      end
   end

   // Refill target: existing matching entry in place, otherwise round-robin slot
   always_comb begin
      wr_hit_c     = 1'b0;
      wr_hit_idx_c = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         if (valid_q[i] && (tag_q[i] == wr_tag) && (sproc_q[i] == wr_sproc)) begin
            wr_hit_c     = 1'b1;
            wr_hit_idx_c = IDX_W'(i);
         end
      end
   end

   assign wr_acc_c = wr_en && (state_q == IDLE) && !inv_all;
   assign wr_idx_c = wr_hit_c ? wr_hit_idx_c : rr_q;

   // Invalidate walker next-state
   always_comb begin
      state_d   = state_q;
      inv_ptr_d = inv_ptr_q;
      clr_c     = 1'b0;
      rr_clr_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (inv_all) begin
               state_d   = WALK;
               inv_ptr_d = '0;
            end
         end
         WALK: begin
            clr_c = 1'b1;
            if (inv_all) begin
               inv_ptr_d = '0;
            end else if (inv_ptr_q == IDX_W'(ENTRIES - 1)) begin
               state_d  = IDLE;
               rr_clr_c = 1'b1;
            end else begin
               inv_ptr_d = inv_ptr_q + IDX_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         inv_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         inv_ptr_q <= inv_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         rr_q    <= '0;
      end else begin
         if (clr_c) valid_q[inv_ptr_q] <= 1'b0;
         if (wr_acc_c) begin
            valid_q[wr_idx_c] <= 1'b1;
            if (!wr_hit_c) rr_q <= rr_q + IDX_W'(1);
         end
         if (rr_clr_c) rr_q <= '0;
      end
   end

   // Entry payload needs no reset; valid bits guard it
   always_ff @(posedge clk) begin
      if (!rst && wr_acc_c) begin
         tag_q[wr_idx_c]   <= wr_tag;
         sproc_q[wr_idx_c] <= wr_sproc;
         data_q[wr_idx_c]  <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tlb_data0    <= '0;
         tlb_data1    <= '0;
         tlb_hit      <= 1'b0;
         tlb_hit_next <= 1'b0;
         wr_ack       <= 1'b0;
         busy         <= 1'b0;
      end else begin
         if (tlb_clkEn && (state_q != WALK)) begin
            tlb_data0    <= data0_c;
            tlb_data1    <= data1_c;
            tlb_hit      <= hit0_c;
            tlb_hit_next <= hit1_c;
         end else begin
            tlb_data0    <= '0;
            tlb_data1    <= '0;
            tlb_hit      <= 1'b0;
            tlb_hit_next <= 1'b0;
         end
         wr_ack <= wr_acc_c;
         busy   <= (state_d == WALK);
      end
   end

endmodule

// File: tb/tb_dtlb_resp.sv
// Directed self-checking bench for dtlb_resp: lookup, next-page wrap, refill/eviction,
// invalidate walk with restart, same-cycle ordering and reset abort.
module tb_dtlb_resp;

   logic        clk;
   logic        rst;
   logic        tlb_clkEn;
   logic [51:0] addrTlb;
   logic [23:0] sproc;
   logic [63:0] tlb_data0, tlb_data1;
   logic        tlb_hit, tlb_hit_next;
   logic        wr_en;
   logic [51:0] wr_tag;
   logic [23:0] wr_sproc;
   logic [63:0] wr_data;
   logic        wr_ack;
   logic        inv_all;
   logic        busy;

   int checks = 0;
   int passed = 0;

   dtlb_resp #(.ENTRIES(16), .TLB_DATA_WIDTH(64), .TLB_IP_WIDTH(52)) dut (
      .clk(clk), .rst(rst),
      .tlb_clkEn(tlb_clkEn), .addrTlb(addrTlb), .sproc(sproc),
      .tlb_data0(tlb_data0), .tlb_data1(tlb_data1),
      .tlb_hit(tlb_hit), .tlb_hit_next(tlb_hit_next),
      .wr_en(wr_en), .wr_tag(wr_tag), .wr_sproc(wr_sproc), .wr_data(wr_data),
      .wr_ack(wr_ack), .inv_all(inv_all), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic refill(input logic [51:0] t, input logic [23:0] sp, input logic [63:0] d);
      wr_en = 1'b1; wr_tag = t; wr_sproc = sp; wr_data = d;
      tick();
      wr_en = 1'b0;
      chk("wr_ack", 64'(wr_ack), 64'd1);
   endtask

   task automatic lookup_chk(input string tag, input logic [51:0] t, input logic [23:0] sp,
                             input logic h0, input logic [63:0] d0,
                             input logic h1, input logic [63:0] d1);
      addrTlb = t; sproc = sp; tlb_clkEn = 1'b1;
      tick();
      tlb_clkEn = 1'b0;
      chk({tag, ".hit"},      64'(tlb_hit),      64'(h0));
      chk({tag, ".data0"},    tlb_data0,         d0);
      chk({tag, ".hit_next"}, 64'(tlb_hit_next), 64'(h1));
      chk({tag, ".data1"},    tlb_data1,         d1);
   endtask

   localparam logic [51:0] T   = 52'h00001_00000010;
   localparam logic [51:0] T1  = 52'h00001_00000011;
   localparam logic [51:0] W0  = {21'd5, 31'h7FFF_FFFF};
   localparam logic [51:0] W1  = {21'd5, 31'd0};
   localparam logic [51:0] S   = {21'd9, 31'd100};
   localparam logic [63:0] D0  = 64'hA0A0_0000_0000_00A1;
   localparam logic [63:0] D1  = 64'hB1B1_0000_0000_00B3;
   localparam logic [63:0] DW0 = 64'h0000_0000_C0C0_0005;
   localparam logic [63:0] DW1 = 64'h0000_0000_D1D1_0007;
   localparam logic [63:0] DS  = 64'h0000_0000_5555_0009;

   function automatic logic [51:0] etag(input int i);
      return {21'd3, 31'(i)};
   endfunction

   initial begin
      int busy_cnt;
      logic any_hit, any_ack, restarted;

      rst = 1'b1; tlb_clkEn = 1'b0; addrTlb = '0; sproc = '0;
      wr_en = 1'b0; wr_tag = '0; wr_sproc = '0; wr_data = '0; inv_all = 1'b0;
      tick(); tick();
      chk("rst.hit",    64'(tlb_hit),   64'd0);
      chk("rst.data0",  tlb_data0,      64'd0);
      chk("rst.wr_ack", 64'(wr_ack),    64'd0);
      chk("rst.busy",   64'(busy),      64'd0);
      rst = 1'b0;

      // Empty array misses
      lookup_chk("empty", T, 24'd0, 1'b0, 64'd0, 1'b0, 64'd0);
      chk("empty.busy",   64'(busy),   64'd0);
      chk("empty.wr_ack", 64'(wr_ack), 64'd0);

      // Two consecutive pages
      refill(T,  24'd0, D0);
      refill(T1, 24'd0, D1);
      lookup_chk("pair", T, 24'd0, 1'b1, D0, 1'b1, D1);
      tick();
      chk("noreq.hit",   64'(tlb_hit),   64'd0);
      chk("noreq.data0", tlb_data0,      64'd0);
      chk("noreq.data1", tlb_data1,      64'd0);

      // Next-page wrap within proc 5; sproc participates in match
      refill(W0, 24'd0, DW0);
      refill(W1, 24'd0, DW1);
      lookup_chk("wrap",    W0, 24'd0, 1'b1, DW0, 1'b1, DW1);
      lookup_chk("sproc1",  W0, 24'd1, 1'b0, 64'd0, 1'b0, 64'd0);
      lookup_chk("next_T1", T1, 24'd0, 1'b1, D1, 1'b0, 64'd0);

      // Same-cycle lookup and refill sees the old array
      wr_en = 1'b1; wr_tag = S; wr_sproc = 24'd0; wr_data = DS;
      addrTlb = S; sproc = 24'd0; tlb_clkEn = 1'b1;
      tick();
      wr_en = 1'b0; tlb_clkEn = 1'b0;
      chk("same.hit",    64'(tlb_hit), 64'd0);
      chk("same.wr_ack", 64'(wr_ack),  64'd1);
      lookup_chk("after_same", S, 24'd0, 1'b1, DS, 1'b0, 64'd0);

      // Fill remaining 11 entries
      for (int i = 0; i < 11; i++) refill({21'd2, 31'(i)}, 24'd0, 64'h200 + 64'(i));

      // Invalidate-all; refill in the same cycle is dropped
      inv_all = 1'b1; wr_en = 1'b1; wr_tag = {21'd7, 31'd99}; wr_sproc = '0;
      tick();
      inv_all = 1'b0; wr_en = 1'b0;
      chk("inv.wr_ack", 64'(wr_ack), 64'd0);
      busy_cnt = 0; any_hit = 1'b0; any_ack = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (busy) busy_cnt++;
         if (tlb_hit || tlb_hit_next) any_hit = 1'b1;
         if (wr_ack) any_ack = 1'b1;
         tlb_clkEn = busy; addrTlb = {21'd2, 31'd14}; sproc = 24'd0;
         wr_en = busy; wr_tag = {21'd7, 31'(k)};
         tick();
      end
      tlb_clkEn = 1'b0; wr_en = 1'b0;
      chk("inv.busy_cycles", 64'(busy_cnt), 64'd16);
      chk("inv.lookup_miss", 64'(any_hit),  64'd0);
      chk("inv.no_ack",      64'(any_ack),  64'd0);
      lookup_chk("post_inv_T",  T,  24'd0, 1'b0, 64'd0, 1'b0, 64'd0);
      lookup_chk("post_inv_W0", W0, 24'd0, 1'b0, 64'd0, 1'b0, 64'd0);
      lookup_chk("post_inv_2x", {21'd2, 31'd5}, 24'd0, 1'b0, 64'd0, 1'b0, 64'd0);

      // Restart at walk cycle 8 stretches busy to 24
      inv_all = 1'b1;
      tick();
      inv_all = 1'b0;
      busy_cnt = 0; restarted = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (busy) busy_cnt++;
         if (busy_cnt == 8 && !restarted) begin
            inv_all = 1'b1; restarted = 1'b1;
         end else begin
            inv_all = 1'b0;
         end
         tick();
      end
      inv_all = 1'b0;
      chk("restart.busy_cycles", 64'(busy_cnt), 64'd24);

      // Eviction from a clean array
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 17; i++) refill(etag(i), 24'd0, 64'h100 + 64'(i));
      lookup_chk("evict_E0", etag(0), 24'd0, 1'b0, 64'd0, 1'b1, 64'h101);
      lookup_chk("keep_E1",  etag(1), 24'd0, 1'b1, 64'h101, 1'b1, 64'h102);
      refill(etag(5), 24'd0, 64'hBEEF);
      lookup_chk("upd_E5",   etag(5), 24'd0, 1'b1, 64'hBEEF, 1'b1, 64'h106);
      refill(etag(17), 24'd0, 64'h111);
      lookup_chk("evict_E1", etag(1),  24'd0, 1'b0, 64'd0, 1'b1, 64'h102);
      lookup_chk("new_E17",  etag(17), 24'd0, 1'b1, 64'h111, 1'b0, 64'd0);
      lookup_chk("E16",      etag(16), 24'd0, 1'b1, 64'h110, 1'b1, 64'h111);

      // Reset mid-walk and mid-refill
      inv_all = 1'b1; tick(); inv_all = 1'b0;
      tick(); tick();
      chk("midwalk.busy", 64'(busy), 64'd1);
      rst = 1'b1; wr_en = 1'b1; wr_tag = {21'd8, 31'd1}; wr_data = 64'h77;
      tick();
      rst = 1'b0; wr_en = 1'b0;
      chk("rst_walk.busy",   64'(busy),   64'd0);
      chk("rst_walk.wr_ack", 64'(wr_ack), 64'd0);
      lookup_chk("rst_walk_E9", etag(9), 24'd0, 1'b0, 64'd0, 1'b0, 64'd0);
      chk("rst_walk.busy2", 64'(busy), 64'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
